// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART TX FIFO drain agent.
//   - state_e    : drain FSM encoding (IDLE=0, START=1, WAIT_DONE=2, GAP=3)
//   - DATA_W_DEF : default FIFO word / tx_data width
//   - timer_w()  : width of the shared gap/timeout down-counter
package uart_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_e;

    // Largest value ever loaded is max(gap, timeout)-1, so clog2(max) bits suffice.
    function automatic int unsigned timer_w(input int unsigned gap, input int unsigned tmo);
        int unsigned m;
        m = (gap > tmo) ? gap : tmo;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/uart_dn_timer.sv
// uart_dn_timer: loadable down-counter with a zero flag; saturates at zero.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_load           : load i_load_val (has priority over i_dec)
//   i_load_val       : value to load
//   i_dec            : decrement by one when nonzero
//   o_zero           : count is zero (decode of the count register)
module uart_dn_timer #(
    parameter int unsigned W = 2
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from a first-word-fall-through TX FIFO and
// hands each to uart_tx via a start/done handshake, with optional inter-frame
// gap, done-timeout watchdog and a wrapping sent-frame counter.
// Ports:
//   i_clk, i_reset_n  : clock, async active-low reset
//   i_en              : permits new pops (sampled in IDLE)
//   i_fifo_empty      : FIFO empty flag
//   i_fifo_rdata      : FIFO head word
//   o_fifo_rd         : one-cycle pop strobe (combinational from state/inputs)
//   o_tx_start        : one-cycle start pulse to the transmitter
//   o_tx_data         : byte presented to the transmitter
//   i_tx_done_tick    : end-of-frame pulse from the transmitter
//   o_busy            : not in IDLE
//   o_err_timeout     : sticky watchdog error
//   i_err_clr         : clears o_err_timeout (a simultaneous new timeout wins)
//   o_frames_sent     : completed frame count, wraps
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rdata,
    output logic              o_fifo_rd,
    output logic              o_tx_start,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_done_tick,
    output logic              o_busy,
    output logic              o_err_timeout,
    input  logic              i_err_clr,
    output logic [CNT_W-1:0]  o_frames_sent
);

    localparam int unsigned TMR_W = timer_w(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TO_LOAD  =
        (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? '0 : TMR_W'(GAP_CYCLES - 1);

    state_e             r_state;
    state_e             w_next;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_err_timeout;
    logic [CNT_W-1:0]   r_frames_sent;

    logic               w_pop;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_dec;
    logic               w_tmr_zero;
    logic               w_frame_done;
    logic               w_timeout;

    // Gap and timeout share one counter: they are never live at the same time
    uart_dn_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Next-state and control decode
    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_dec    = 1'b0;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_en && !i_fifo_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TO_LOAD;
                w_next     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done is checked first so it wins over a same-cycle expiry
                if (i_tx_done_tick) begin
                    w_frame_done = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = GAP_LOAD;
                        w_next     = ST_GAP;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && w_tmr_zero) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) begin
                    w_next = ST_IDLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, datapath and status registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_frames_sent <= '0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= (w_next == ST_START);
            r_busy     <= (w_next != ST_IDLE);
            if (w_pop) begin
                r_tx_data <= i_fifo_rdata;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (i_err_clr) begin
                r_err_timeout <= 1'b0;
            end
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + CNT_W'(1);
            end
        end
    end

    // Reset gating keeps the pop strobe low while reset is held
    assign o_fifo_rd     = w_pop & i_reset_n;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_busy        = r_busy;
    assign o_err_timeout = r_err_timeout;
    assign o_frames_sent = r_frames_sent;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: DUT A (GAP=0, TIMEOUT=20, 4-bit counter) and
// DUT B (GAP=4, no watchdog), each with a FIFO model, transmitter model and
// a scoreboard monitor checking every tx_start byte against queued pushes.
module tb_uart_tx_fifo_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A signals / models ----------------
    logic       a_en, a_err_clr, a_spur, a_done_m, a_done;
    logic       a_empty, a_rd, a_start, a_busy, a_err;
    logic [7:0] a_rdata, a_tx_data;
    logic [3:0] a_frames;
    logic [7:0] a_mem [16];
    int         a_wp = 0, a_rp = 0, a_delay = 10, a_cnt;
    logic [7:0] exp_a [$];

    assign a_empty = (a_wp == a_rp);
    assign a_rdata = a_mem[a_rp[3:0]];
    assign a_done  = a_done_m | a_spur;

    uart_tx_fifo_drain #(
        .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20), .CNT_W(4)
    ) u_dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_en(a_en),
        .i_fifo_empty(a_empty), .i_fifo_rdata(a_rdata), .o_fifo_rd(a_rd),
        .o_tx_start(a_start), .o_tx_data(a_tx_data), .i_tx_done_tick(a_done),
        .o_busy(a_busy), .o_err_timeout(a_err), .i_err_clr(a_err_clr),
        .o_frames_sent(a_frames)
    );

    always @(posedge clk) if (a_rd) a_rp <= a_rp + 1;

    // Transmitter model: done pulse a_delay cycles after the start cycle (0 = never)
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt <= 0; a_done_m <= 1'b0;
        end else begin
            a_done_m <= 1'b0;
            if (a_start && a_delay != 0) a_cnt <= a_delay - 1;
            else if (a_cnt == 1) begin a_done_m <= 1'b1; a_cnt <= 0; end
            else if (a_cnt > 1) a_cnt <= a_cnt - 1;
        end
    end

    // ---------------- DUT B signals / models ----------------
    logic       b_en, b_err_clr, b_spur, b_done_m, b_done;
    logic       b_empty, b_rd, b_start, b_busy, b_err;
    logic [7:0] b_rdata, b_tx_data;
    logic [15:0] b_frames;
    logic [7:0] b_mem [16];
    int         b_wp = 0, b_rp = 0, b_delay = 40, b_cnt;
    logic [7:0] exp_b [$];

    assign b_empty = (b_wp == b_rp);
    assign b_rdata = b_mem[b_rp[3:0]];
    assign b_done  = b_done_m | b_spur;

    uart_tx_fifo_drain #(
        .DATA_W(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(0), .CNT_W(16)
    ) u_dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_en(b_en),
        .i_fifo_empty(b_empty), .i_fifo_rdata(b_rdata), .o_fifo_rd(b_rd),
        .o_tx_start(b_start), .o_tx_data(b_tx_data), .i_tx_done_tick(b_done),
        .o_busy(b_busy), .o_err_timeout(b_err), .i_err_clr(b_err_clr),
        .o_frames_sent(b_frames)
    );

    always @(posedge clk) if (b_rd) b_rp <= b_rp + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_cnt <= 0; b_done_m <= 1'b0;
        end else begin
            b_done_m <= 1'b0;
            if (b_start && b_delay != 0) b_cnt <= b_delay - 1;
            else if (b_cnt == 1) begin b_done_m <= 1'b1; b_cnt <= 0; end
            else if (b_cnt > 1) b_cnt <= b_cnt - 1;
        end
    end

    // ---------------- check helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard monitors: compare every presented byte against the push order
    always @(negedge clk) begin
        if (a_start) begin
            if (exp_a.size() == 0) fail_now("a_unexpected_start");
            else check("a_tx_data", 32'(a_tx_data), 32'(exp_a.pop_front()));
        end
        if (a_rd) check("a_rd_nonempty", 32'(a_empty), 32'd0);
        if (b_start) begin
            if (exp_b.size() == 0) fail_now("b_unexpected_start");
            else check("b_tx_data", 32'(b_tx_data), 32'(exp_b.pop_front()));
        end
        if (b_rd) check("b_rd_nonempty", 32'(b_empty), 32'd0);
    end

    task automatic push_a(input logic [7:0] v);
        a_mem[a_wp[3:0]] = v;
        a_wp = a_wp + 1;
        exp_a.push_back(v);
    endtask

    task automatic push_b(input logic [7:0] v);
        b_mem[b_wp[3:0]] = v;
        b_wp = b_wp + 1;
        exp_b.push_back(v);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // which: 0=fifo_rd 1=tx_start 2=tx_done_tick 3=err_timeout
    function automatic logic sig(input int d, input int which);
        case (which)
            0: return (d == 0) ? a_rd    : b_rd;
            1: return (d == 0) ? a_start : b_start;
            2: return (d == 0) ? a_done  : b_done;
            default: return (d == 0) ? a_err : b_err;
        endcase
    endfunction

    task automatic wait_for(input int d, input int which, input int budget,
                            input string nm, output int t);
        t = -1;
        #1;
        for (int i = 0; i <= budget; i++) begin
            if (sig(d, which)) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) fail_now(nm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_rd, t_s, t_d, t_e, rd_seen;
        reset_n = 1'b0;
        a_en = 1'b1; a_err_clr = 1'b0; a_spur = 1'b0;
        b_en = 1'b1; b_err_clr = 1'b0; b_spur = 1'b0;
        t_d = 0;

        // Reset values, with a byte already waiting and en high
        push_a(8'hA5);
        repeat (3) step();
        check("rst_fifo_rd",  32'(a_rd),      32'd0);
        check("rst_tx_start", 32'(a_start),   32'd0);
        check("rst_tx_data",  32'(a_tx_data), 32'd0);
        check("rst_busy",     32'(a_busy),    32'd0);
        check("rst_err",      32'(a_err),     32'd0);
        check("rst_frames",   32'(a_frames),  32'd0);
        reset_n = 1'b1;

        // Single byte
        wait_for(0, 0, 5, "single_rd", t_rd);
        step();
        check("single_rd_one_cycle", 32'(a_rd),    32'd0);
        check("single_start_t1",     32'(a_start), 32'd1);
        wait_for(0, 2, 15, "single_done", t_d);
        check("single_busy_at_done", 32'(a_busy), 32'd1);
        step();
        check("single_busy_fall", 32'(a_busy),   32'd0);
        check("single_frames",    32'(a_frames), 32'd1);

        // Back-to-back, no gap
        push_a(8'h01); push_a(8'h02); push_a(8'h03);
        for (int k = 0; k < 3; k++) begin
            wait_for(0, 0, 20, "b2b_rd", t_rd);
            if (k > 0) check("b2b_rd_after_done", 32'(t_rd - t_d), 32'd1);
            wait_for(0, 2, 20, "b2b_done", t_d);
        end
        step();
        check("b2b_frames",     32'(a_frames), 32'd4);
        check("b2b_fifo_empty", 32'(a_empty),  32'd1);
        check("b2b_idle",       32'(a_busy),   32'd0);

        // Timeout with no done
        a_delay = 0;
        push_a(8'h5A);
        wait_for(0, 0, 5, "to_rd", t_rd);
        step();
        t_s = cyc;
        check("to_start", 32'(a_start), 32'd1);
        wait_for(0, 3, 30, "to_err", t_e);
        check("to_latency", 32'(t_e - t_s), 32'd21);
        check("to_idle",    32'(a_busy),    32'd0);
        check("to_frames",  32'(a_frames),  32'd4);
        a_err_clr = 1'b1;
        step();
        a_err_clr = 1'b0;
        check("to_clear", 32'(a_err), 32'd0);

        // Done in the expiry cycle wins
        a_delay = 20;
        push_a(8'h3C);
        wait_for(0, 0, 5, "exp_rd", t_rd);
        wait_for(0, 2, 30, "exp_done", t_d);
        step();
        check("exp_no_err", 32'(a_err),    32'd0);
        check("exp_frames", 32'(a_frames), 32'd5);

        // Timeout set beats a held clear
        a_delay = 0;
        push_a(8'h77);
        wait_for(0, 0, 5, "setwin_rd", t_rd);
        step();
        t_s = cyc;
        a_err_clr = 1'b1;
        wait_for(0, 3, 30, "setwin_err", t_e);
        check("setwin_latency", 32'(t_e - t_s), 32'd21);
        a_err_clr = 1'b0;
        step();
        check("setwin_sticky", 32'(a_err),    32'd1);
        check("setwin_frames", 32'(a_frames), 32'd5);
        a_err_clr = 1'b1;
        step();
        a_err_clr = 1'b0;
        check("setwin_clear", 32'(a_err), 32'd0);

        // en dropped mid-frame, then a spurious done in IDLE
        a_delay = 10;
        push_a(8'h11); push_a(8'h22);
        wait_for(0, 0, 5, "en_rd", t_rd);
        step();
        step();
        a_en = 1'b0;
        wait_for(0, 2, 20, "en_done", t_d);
        step();
        check("en_idle",   32'(a_busy),   32'd0);
        check("en_frames", 32'(a_frames), 32'd6);
        rd_seen = 0;
        repeat (15) begin
            step();
            if (a_rd) rd_seen = 1;
        end
        check("en_no_pop", 32'(rd_seen), 32'd0);
        a_spur = 1'b1;
        step();
        a_spur = 1'b0;
        step();
        check("spur_idle_frames", 32'(a_frames), 32'd6);
        a_en = 1'b1;
        wait_for(0, 0, 5, "en_resume_rd", t_rd);
        wait_for(0, 2, 20, "en_resume_done", t_d);
        step();
        check("en_resume_frames", 32'(a_frames), 32'd7);

        // Counter wrap (4-bit): 9 more frames take 7 -> 0
        for (int k = 0; k < 9; k++) push_a(8'(8'h80 + k));
        for (int k = 0; k < 9; k++) begin
            wait_for(0, 2, 30, "wrap_done", t_d);
            step();
            check("wrap_frames", 32'(a_frames), 32'((8 + k) % 16));
        end

        // Reset mid-frame (WAIT_DONE), with another byte queued
        push_a(8'h99); push_a(8'hAB);
        wait_for(0, 0, 5, "rstmid_rd", t_rd);
        step();
        step();
        step();
        check("rstmid_busy_before", 32'(a_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_fifo_rd",  32'(a_rd),      32'd0);
        check("rstmid_tx_start", 32'(a_start),   32'd0);
        check("rstmid_tx_data",  32'(a_tx_data), 32'd0);
        check("rstmid_busy",     32'(a_busy),    32'd0);
        check("rstmid_frames",   32'(a_frames),  32'd0);
        step();
        reset_n = 1'b1;
        wait_for(0, 0, 5, "rstmid_restart_rd", t_rd);
        step();
        check("rstmid_restart_start", 32'(a_start), 32'd1);
        wait_for(0, 2, 20, "rstmid_restart_done", t_d);
        step();
        check("rstmid_restart_frames", 32'(a_frames), 32'd1);

        // DUT B: 4-cycle gap, watchdog disabled, spurious done in GAP
        b_delay = 40;
        push_b(8'hC1); push_b(8'hC2);
        wait_for(1, 0, 5, "gap_rd1", t_rd);
        wait_for(1, 2, 50, "gap_done1", t_d);
        check("gap_no_watchdog", 32'(b_err), 32'd0);
        b_delay = 10;
        step();
        check("gap_busy", 32'(b_busy), 32'd1);
        b_spur = 1'b1;
        step();
        b_spur = 1'b0;
        wait_for(1, 0, 10, "gap_rd2", t_rd);
        check("gap_rd_latency", 32'(t_rd - t_d), 32'd5);
        check("gap_spur_frames", 32'(b_frames), 32'd1);
        wait_for(1, 2, 20, "gap_done2", t_d);
        step();
        check("gap_frames", 32'(b_frames), 32'd2);
        repeat (6) step();
        check("gap_final_idle", 32'(b_busy), 32'd0);
        check("sb_a_drained", 32'(exp_a.size()), 32'd0);
        check("sb_b_drained", 32'(exp_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound on run time
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
